// File: rtl/sc_sys_pkg.sv
// Shared constants, types and helpers for the round-robin traffic system core.
package sc_sys_pkg;

    localparam int unsigned LFSR_W = 16;
    // Fibonacci feedback taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned       N_MST_DEF = 4;
    localparam int unsigned       N_SLV_DEF = 4;
    localparam int unsigned       SEQ_W_DEF = 6;
    localparam logic [LFSR_W-1:0] SEED_DEF  = 16'hACE1;

    localparam int unsigned MST_W = $clog2(N_MST_DEF);
    localparam int unsigned SLV_W = $clog2(N_SLV_DEF);

    // Word carried from a master to a slave: source id and sequence number
    typedef struct packed {
        logic [MST_W-1:0]     src;
        logic [SEQ_W_DEF-1:0] seq;
    } word_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mst_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sc_rr_arb.sv
// N-way round-robin arbiter: one-hot grant, pointer advances past the winner on handshake.
module sc_rr_arb
    import sc_sys_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         hs_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned W = $clog2(N);
    localparam logic [W-1:0] PTR_ONE = 1;

    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx, gidx;
    logic         found;

    // Scan requests from the pointer upward, wrapping, and grant the first one
    always_comb begin
        gnt_o = '0;
        gidx  = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr_q + W'(i);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) begin
            gnt_o[gidx] = 1'b1;
        end
    end

    // Pointer moves to one past the winner only when the transfer completes
    always_comb begin
        ptr_d = ptr_q;
        if (hs_i) begin
            ptr_d = gidx + PTR_ONE;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sc_rr_sys_core.sv
// System core: LFSR traffic masters feed sequence-checking slaves through a round-robin crossbar.
module sc_rr_sys_core
    import sc_sys_pkg::*;
#(
    parameter int unsigned       N_MST = N_MST_DEF,
    parameter int unsigned       N_SLV = N_SLV_DEF,
    parameter int unsigned       SEQ_W = SEQ_W_DEF,
    parameter logic [LFSR_W-1:0] SEED  = SEED_DEF
) (
    input  logic        i_clk,
    input  logic        i_resetb,
    output logic        o_err,
    output logic [15:0] o_txn_cnt
);

    localparam int unsigned MW     = $clog2(N_MST);
    localparam int unsigned SW     = $clog2(N_SLV);
    localparam int unsigned WORD_W = MW + SEQ_W;
    localparam logic [SEQ_W-1:0] SEQ_ONE = 1;

    // Master state
    mst_state_e        st_q    [N_MST];
    mst_state_e        st_d    [N_MST];
    logic [SW-1:0]     dest_q  [N_MST];
    logic [SW-1:0]     dest_d  [N_MST];
    logic [SEQ_W-1:0]  wseq_q  [N_MST];
    logic [SEQ_W-1:0]  wseq_d  [N_MST];
    logic [SEQ_W-1:0]  seq_q   [N_MST][N_SLV];
    logic [SEQ_W-1:0]  seq_d   [N_MST][N_SLV];
    logic [LFSR_W-1:0] mlfsr_q [N_MST];
    logic [N_MST-1:0]  mst_rdy;

    // Slave state
    logic [LFSR_W-1:0] slfsr_q [N_SLV];
    logic [SEQ_W-1:0]  exp_q   [N_SLV][N_MST];
    logic [SEQ_W-1:0]  exp_d   [N_SLV][N_MST];
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [N_SLV-1:0]  slv_rdy;
    logic [N_SLV-1:0]  slv_hs;

    // Arbitration and crossbar
    logic [N_MST-1:0]               arb_req [N_SLV];
    logic [N_MST-1:0]               gnt     [N_SLV];
    logic [N_SLV-1:0][WORD_W-1:0]   xbar_c;
    logic [N_SLV-1:0][WORD_W-1:0]   slv_word;

    for (genvar s = 0; s < N_SLV; s++) begin : g_arb
        sc_rr_arb #(.N(N_MST)) u_arb (
            .clk_i (i_clk),
            .rst_i (i_resetb),
            .req_i (arb_req[s]),
            .hs_i  (slv_hs[s]),
            .gnt_o (gnt[s])
        );
    end

    // Each arbiter sees the masters currently requesting its slave
    always_comb begin
        for (int unsigned s = 0; s < N_SLV; s++) begin
            for (int unsigned m = 0; m < N_MST; m++) begin
                arb_req[s][m] = (st_q[m] == REQ) && (dest_q[m] == SW'(s));
            end
        end
    end

    // Slave ready, handshake detect and AND-OR data select of the granted master
    always_comb begin
        for (int unsigned s = 0; s < N_SLV; s++) begin
            slv_rdy[s] = slfsr_q[s][1] | slfsr_q[s][0];
            slv_hs[s]  = (|gnt[s]) & slv_rdy[s];
            xbar_c[s]  = '0;
            for (int unsigned m = 0; m < N_MST; m++) begin
                if (gnt[s][m]) begin
                    xbar_c[s] = xbar_c[s] | {MW'(m), wseq_q[m]};
                end
            end
        end
    end

    assign slv_word = xbar_c;

    // Master ready: granted by its destination arbiter and that slave is ready
    always_comb begin
        for (int unsigned m = 0; m < N_MST; m++) begin
            mst_rdy[m] = gnt[dest_q[m]][m] & slv_rdy[dest_q[m]];
        end
    end

    // Master FSM next state: latch a destination and word, hold it until accepted
    always_comb begin
        st_d   = st_q;
        dest_d = dest_q;
        wseq_d = wseq_q;
        seq_d  = seq_q;
        for (int unsigned m = 0; m < N_MST; m++) begin
            case (st_q[m])
                IDLE: begin
                    if (mlfsr_q[m][0]) begin
                        st_d[m]   = REQ;
                        dest_d[m] = mlfsr_q[m][SW:1];
                        wseq_d[m] = seq_q[m][mlfsr_q[m][SW:1]];
                    end
                end
                REQ: begin
                    if (mst_rdy[m]) begin
                        st_d[m]              = IDLE;
                        seq_d[m][dest_q[m]]  = seq_q[m][dest_q[m]] + SEQ_ONE;
                    end
                end
                default: st_d[m] = IDLE;
            endcase
        end
    end

    // Slave checking and handshake counting
    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        cnt_d = cnt_q;
        for (int unsigned s = 0; s < N_SLV; s++) begin
            if (slv_hs[s]) begin
                if (slv_word[s][SEQ_W-1:0] != exp_q[s][slv_word[s][WORD_W-1:SEQ_W]]) begin
                    err_d = 1'b1;
                end
                exp_d[s][slv_word[s][WORD_W-1:SEQ_W]] = slv_word[s][SEQ_W-1:0] + SEQ_ONE;
                cnt_d = cnt_d + 16'd1;
            end
        end
    end

    // State registers; LFSRs reload their seeds in reset and free-run otherwise
    always_ff @(posedge i_clk) begin
        if (i_resetb) begin
            for (int unsigned m = 0; m < N_MST; m++) begin
                st_q[m]    <= IDLE;
                dest_q[m]  <= '0;
                wseq_q[m]  <= '0;
                mlfsr_q[m] <= SEED ^ LFSR_W'(m + 1);
                for (int unsigned d = 0; d < N_SLV; d++) begin
                    seq_q[m][d] <= '0;
                end
            end
            for (int unsigned s = 0; s < N_SLV; s++) begin
                slfsr_q[s] <= SEED ^ (LFSR_W'(16'h0100) << s);
                for (int unsigned m = 0; m < N_MST; m++) begin
                    exp_q[s][m] <= '0;
                end
            end
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            st_q   <= st_d;
            dest_q <= dest_d;
            wseq_q <= wseq_d;
            seq_q  <= seq_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            for (int unsigned m = 0; m < N_MST; m++) begin
                mlfsr_q[m] <= lfsr_next(mlfsr_q[m]);
            end
            for (int unsigned s = 0; s < N_SLV; s++) begin
                slfsr_q[s] <= lfsr_next(slfsr_q[s]);
            end
        end
    end

    assign o_err     = err_q;
    assign o_txn_cnt = cnt_q;

endmodule

// File: tb/tb_sc_rr_sys_core.sv
// Cycle-level scoreboard bench for sc_rr_sys_core.
`timescale 1ns/1ps
module tb_sc_rr_sys_core;
    import sc_sys_pkg::*;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int SQ = 6;
    localparam int WW = $bits(word_t);
    localparam logic [15:0] SD = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err;
    logic [15:0] cnt;

    sc_rr_sys_core #(.N_MST(NM), .N_SLV(NS), .SEQ_W(SQ), .SEED(SD)) dut (
        .i_clk     (clk),
        .i_resetb  (rst),
        .o_err     (err),
        .o_txn_cnt (cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state
    bit          m_req   [NM];
    int          m_dest  [NM];
    int          m_wseq  [NM];
    int          m_seq   [NM][NS];
    logic [15:0] m_mlfsr [NM];
    logic [15:0] m_slfsr [NS];
    int          m_exp   [NS][NM];
    int          m_ptr   [NS];
    bit          m_err;
    logic [15:0] m_cnt;
    bit          m_wrapped;

    // Model combinational view of the current cycle
    int   c_g  [NS];
    bit   c_hs [NS];
    logic [NM-1:0] d_gnt [NS];

    bit   inj     = 1'b0;
    int   inj_seq = 0;
    logic [NS*WW-1:0] fv;

    function automatic logic [15:0] lf(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [NM-1:0] oh(input int g);
        logic [NM-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic model_comb();
        for (int s = 0; s < NS; s++) begin
            c_g[s] = -1;
            for (int i = 0; i < NM; i++) begin
                int m;
                m = (m_ptr[s] + i) % NM;
                if (c_g[s] < 0 && m_req[m] && m_dest[m] == s) c_g[s] = m;
            end
            c_hs[s] = (c_g[s] >= 0) && (m_slfsr[s][1] || m_slfsr[s][0]);
        end
    endtask

    // Advance model and DUT one clock; expected outputs go to the scoreboard
    task automatic step();
        exp_t e;
        bit   done [NM];
        model_comb();
        for (int s = 0; s < NS; s++) d_gnt[s] = dut.gnt[s];
        if (rst) begin
            for (int m = 0; m < NM; m++) begin
                m_req[m] = 1'b0; m_dest[m] = 0; m_wseq[m] = 0;
                m_mlfsr[m] = SD ^ 16'(m + 1);
                for (int d = 0; d < NS; d++) m_seq[m][d] = 0;
            end
            for (int s = 0; s < NS; s++) begin
                m_slfsr[s] = SD ^ (16'h0100 << s);
                m_ptr[s] = 0;
                for (int m = 0; m < NM; m++) m_exp[s][m] = 0;
            end
            m_err = 1'b0; m_cnt = '0; m_wrapped = 1'b0;
        end else begin
            for (int m = 0; m < NM; m++) done[m] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if (c_hs[s]) begin
                    int g, sq;
                    g  = c_g[s];
                    sq = (inj && s == 0) ? inj_seq : m_wseq[g];
                    if (sq != m_exp[s][g]) m_err = 1'b1;
                    m_exp[s][g] = (sq + 1) % (1 << SQ);
                    m_cnt = m_cnt + 16'd1;
                    m_ptr[s] = (g + 1) % NM;
                    if (g == 0 && m_dest[0] == 0 && m_seq[0][0] == (1 << SQ) - 1) m_wrapped = 1'b1;
                    m_seq[g][m_dest[g]] = (m_seq[g][m_dest[g]] + 1) % (1 << SQ);
                    m_req[g] = 1'b0;
                    done[g]  = 1'b1;
                end
            end
            for (int m = 0; m < NM; m++) begin
                if (!done[m] && !m_req[m] && m_mlfsr[m][0]) begin
                    m_req[m]  = 1'b1;
                    m_dest[m] = int'(m_mlfsr[m][2:1]);
                    m_wseq[m] = m_seq[m][m_dest[m]];
                end
            end
            for (int m = 0; m < NM; m++) m_mlfsr[m] = lf(m_mlfsr[m]);
            for (int s = 0; s < NS; s++) m_slfsr[s] = lf(m_slfsr[s]);
        end
        e.err = m_err;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if (err !== e.err || err !== 1'b0) begin
                failures++;
                $display("FAIL reset_err cyc=%0d got=%b exp=0", cyc, err);
            end
            checks++;
            if (cnt !== e.cnt || cnt !== 16'd0) begin
                failures++;
                $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", cyc, cnt);
            end
        end
    endtask

    task automatic test_traffic(input int n, input string tag);
        exp_t e;
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if (err !== e.err) begin
                failures++;
                $display("FAIL %s_err cyc=%0d got=%b exp=%b", tag, cyc, err, e.err);
            end
            checks++;
            if (cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s_cnt cyc=%0d got=%0d exp=%0d", tag, cyc, cnt, e.cnt);
            end
            for (int s = 0; s < NS; s++) begin
                checks++;
                if (d_gnt[s] !== oh(c_g[s])) begin
                    failures++;
                    $display("FAIL %s_gnt%0d cyc=%0d got=%b exp=%b", tag, s, cyc, d_gnt[s], oh(c_g[s]));
                end
            end
        end
    endtask

    task automatic test_run_1000();
        test_traffic(1000, "run");
        checks++;
        if (!(cnt > 16'd0 && cnt <= 16'd4000)) begin
            failures++;
            $display("FAIL run_range got=%0d exp=1..4000", cnt);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 400 && !m_wrapped; i++) test_traffic(50, "wrap");
        checks++;
        if (!m_wrapped) begin
            failures++;
            $display("FAIL wrap_timeout got=no_wrap exp=seq00_wrapped");
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_err got=%b exp=0", err);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        test_traffic(50, "pre_rst");
        rst = 1'b1;
        step();
        e = sb.pop_front();
        checks++;
        if (cnt !== e.cnt || cnt !== 16'd0) begin
            failures++;
            $display("FAIL midrst_cnt got=%0d exp=0", cnt);
        end
        rst = 1'b0;
        // All masters IDLE after reset: no grants anywhere on the next cycle
        test_traffic(1, "midrst_idle");
        for (int s = 0; s < NS; s++) begin
            checks++;
            if (d_gnt[s] !== '0) begin
                failures++;
                $display("FAIL midrst_gnt%0d got=%b exp=0", s, d_gnt[s]);
            end
        end
        test_traffic(200, "post_rst");
    endtask

    task automatic test_err_inject();
        exp_t e;
        bit   found;
        rst = 1'b1;
        step();
        void'(sb.pop_front());
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            model_comb();
            if (c_hs[0] && m_exp[0][c_g[0]] == 5) begin
                found = 1'b1;
                fv = '0;
                for (int s = 0; s < NS; s++) begin
                    if (c_g[s] >= 0) begin
                        word_t w;
                        w.src = MST_W'(c_g[s]);
                        w.seq = (s == 0) ? 6'd7 : 6'(m_wseq[c_g[s]]);
                        fv[s*WW +: WW] = w;
                    end
                end
                inj = 1'b1;
                inj_seq = 7;
                force dut.slv_word = fv;
            end
            step();
            if (found) begin
                release dut.slv_word;
                inj = 1'b0;
            end
            e = sb.pop_front();
            checks++;
            if (err !== e.err) begin
                failures++;
                $display("FAIL inj_err cyc=%0d got=%b exp=%b", cyc, err, e.err);
            end
            checks++;
            if (cnt !== e.cnt) begin
                failures++;
                $display("FAIL inj_cnt cyc=%0d got=%0d exp=%0d", cyc, cnt, e.cnt);
            end
        end
        checks++;
        if (!found || err !== 1'b1) begin
            failures++;
            $display("FAIL inj_detect found=%b got=%b exp=1", found, err);
        end
        test_traffic(40, "inj_sticky");
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL inj_sticky_end got=%b exp=1", err);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run_1000();
        test_wrap();
        test_mid_reset();
        test_err_inject();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
